// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Brief    : Handshake and shared-field bundle between a pipeline stage and
//            its upstream/downstream neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int TNEW_W = 2,
    parameter int EXC_W  = 5
);
    logic              flush;
    logic              bubble;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic              in_ds;
    logic [EXC_W-1:0]  in_exc;
    logic [TNEW_W-1:0] in_tnew;
    logic              in_regwrite;
    logic [4:0]        in_wreg;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic              out_ds;
    logic [EXC_W-1:0]  out_exc;
    logic [TNEW_W-1:0] out_tnew;
    logic              out_regwrite;
    logic [4:0]        out_wreg;

    modport master (
        output flush, bubble,
        output in_valid, in_data, in_pc, in_ds, in_exc, in_tnew, in_regwrite, in_wreg,
        input  in_ready,
        output out_ready,
        input  out_valid, out_data, out_pc, out_ds, out_exc, out_tnew, out_regwrite, out_wreg
    );

    modport slave (
        input  flush, bubble,
        input  in_valid, in_data, in_pc, in_ds, in_exc, in_tnew, in_regwrite, in_wreg,
        output in_ready,
        input  out_ready,
        output out_valid, out_data, out_pc, out_ds, out_exc, out_tnew, out_regwrite, out_wreg
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : MIPS pipeline-stage register with valid/ready handshake, bubble
//            insertion, exception flush and an optional one-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int               DATA_W            = 128,
    parameter int               TNEW_W            = 2,
    parameter int               EXC_W             = 5,
    parameter logic [EXC_W-1:0] EXC_NONE          = '0,
    parameter logic [31:0]      FLUSH_PC          = 32'h0000_4180,
    parameter bit               KEEP_PC_ON_BUBBLE = 1'b1,
    parameter bit               SKID              = 1'b0
) (
    input wire              clk,
    input wire              rst,
    pipe_stage_reg_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
        logic              ds;
        logic [EXC_W-1:0]  exc;
        logic [TNEW_W-1:0] tnew;
        logic              regwrite;
        logic [4:0]        wreg;
    } entry_t;

    typedef enum logic [0:0] {
        c_ST_EMPTY = 1'b0,
        c_ST_FULL  = 1'b1
    } skid_state_t;

    localparam entry_t c_IDLE_ENTRY = {
        {DATA_W{1'b0}}, 32'h0, 1'b0, EXC_NONE, {TNEW_W{1'b0}}, 1'b0, 5'd0
    };

    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        valid_q, valid_d;
    skid_state_t state_q, state_d;

    logic   w_free;
    logic   w_in_ready;
    logic   w_t_in;
    entry_t w_in_entry;

    function automatic logic [TNEW_W-1:0] f_dec_tnew(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    assign w_free     = !valid_q || bus.out_ready;
    assign w_in_entry = {bus.in_data, bus.in_pc, bus.in_ds, bus.in_exc,
                         bus.in_tnew, bus.in_regwrite, bus.in_wreg};

    // With the skid present, in_ready depends only on registered state so the
    // downstream ready never reaches the upstream combinationally.
    generate
        if (SKID) begin : g_skid_ready
            assign w_in_ready = (state_q == c_ST_EMPTY) && !bus.bubble;
        end else begin : g_direct_ready
            assign w_in_ready = w_free && !bus.bubble;
        end
    endgenerate

    assign w_t_in = bus.in_valid && w_in_ready;

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        skid_d  = skid_q;
        state_d = state_q;

        if (bus.flush) begin
            valid_d   = 1'b0;
            main_d    = c_IDLE_ENTRY;
            main_d.pc = FLUSH_PC;
            skid_d    = c_IDLE_ENTRY;
            state_d   = c_ST_EMPTY;
        end else if (state_q == c_ST_FULL) begin
            // Skid drains before anything else, including a pending bubble.
            if (w_free) begin
                valid_d     = 1'b1;
                main_d      = skid_q;
                main_d.tnew = f_dec_tnew(skid_q.tnew);
                state_d     = c_ST_EMPTY;
            end
        end else if (bus.bubble) begin
            if (w_free) begin
                valid_d = 1'b0;
                main_d  = c_IDLE_ENTRY;
                if (KEEP_PC_ON_BUBBLE) begin
                    main_d.pc = bus.in_pc;
                    main_d.ds = bus.in_ds;
                end
            end
        end else if (w_t_in) begin
            if (w_free) begin
                valid_d     = 1'b1;
                main_d      = w_in_entry;
                main_d.tnew = f_dec_tnew(bus.in_tnew);
            end else begin
                skid_d  = w_in_entry;
                state_d = c_ST_FULL;
            end
        end else if (w_free) begin
            valid_d = 1'b0;
            main_d  = c_IDLE_ENTRY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            main_q  <= c_IDLE_ENTRY;
            skid_q  <= c_IDLE_ENTRY;
            state_q <= c_ST_EMPTY;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            state_q <= state_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_data     = main_q.data;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_ds       = main_q.ds;
    assign bus.out_exc      = main_q.exc;
    assign bus.out_tnew     = main_q.tnew;
    assign bus.out_regwrite = main_q.regwrite && valid_q;
    assign bus.out_wreg     = main_q.wreg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed and randomised bench for pipe_stage_reg in both skid modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(128), .TNEW_W(2), .EXC_W(5)) if0 ();
    pipe_stage_reg_if #(.DATA_W(128), .TNEW_W(2), .EXC_W(5)) if1 ();

    pipe_stage_reg #(.SKID(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    pipe_stage_reg #(.SKID(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic         valid;
        logic         in_ready;
        logic         ds;
        logic         rw;
        logic [127:0] data;
        logic [31:0]  pc;
        logic [4:0]   exc;
        logic [4:0]   wreg;
        logic [1:0]   tnew;
    } obs_t;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  tnew;
    } exp_t;

    function automatic logic [127:0] mk_data(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'hA5A5_A5A5, pc | 32'h1234_0000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int d, output obs_t o);
        if (d == 0) begin
            o.valid = if0.out_valid; o.in_ready = if0.in_ready; o.ds = if0.out_ds;
            o.rw = if0.out_regwrite; o.data = if0.out_data; o.pc = if0.out_pc;
            o.exc = if0.out_exc; o.wreg = if0.out_wreg; o.tnew = if0.out_tnew;
        end else begin
            o.valid = if1.out_valid; o.in_ready = if1.in_ready; o.ds = if1.out_ds;
            o.rw = if1.out_regwrite; o.data = if1.out_data; o.pc = if1.out_pc;
            o.exc = if1.out_exc; o.wreg = if1.out_wreg; o.tnew = if1.out_tnew;
        end
    endtask

    task automatic drive_one(input int d, input logic v, input logic bub, input logic ordy,
                             input logic [31:0] pc, input logic [1:0] tn, input logic ds,
                             input logic [4:0] exc, input logic rw, input logic [4:0] wr);
        if (d == 0) begin
            if0.in_valid = v; if0.bubble = bub; if0.out_ready = ordy; if0.in_pc = pc;
            if0.in_data = mk_data(pc); if0.in_tnew = tn; if0.in_ds = ds; if0.in_exc = exc;
            if0.in_regwrite = rw; if0.in_wreg = wr;
        end else begin
            if1.in_valid = v; if1.bubble = bub; if1.out_ready = ordy; if1.in_pc = pc;
            if1.in_data = mk_data(pc); if1.in_tnew = tn; if1.in_ds = ds; if1.in_exc = exc;
            if1.in_regwrite = rw; if1.in_wreg = wr;
        end
    endtask

    task automatic drive_both(input logic v, input logic bub, input logic ordy,
                              input logic [31:0] pc, input logic [1:0] tn, input logic ds,
                              input logic [4:0] exc, input logic rw, input logic [4:0] wr);
        drive_one(0, v, bub, ordy, pc, tn, ds, exc, rw, wr);
        drive_one(1, v, bub, ordy, pc, tn, ds, exc, rw, wr);
    endtask

    task automatic set_flush(input logic f);
        if0.flush = f;
        if1.flush = f;
    endtask

    task automatic test_reset();
        obs_t o;
        set_flush(1'b0);
        drive_both(1'b1, 1'b0, 1'b0, 32'hDEAD_BEE0, 2'd3, 1'b1, 5'h1F, 1'b1, 5'd7);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        drive_both(1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 5'h0, 1'b0, 5'd0);
        #1;
        for (int d = 0; d < 2; d++) begin
            snap(d, o);
            n_checks++;
            if ({o.valid, o.pc, o.ds, o.exc, o.tnew, o.rw, o.wreg, o.data, o.in_ready} !==
                {1'b0, 32'h0, 1'b0, 5'h0, 2'd0, 1'b0, 5'd0, 128'h0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset dut%0d: got valid=%0b pc=%h ds=%0b exc=%h tnew=%0d rw=%0b wreg=%0d in_ready=%0b, want all zero and in_ready=1",
                         d, o.valid, o.pc, o.ds, o.exc, o.tnew, o.rw, o.wreg, o.in_ready);
            end
        end
    endtask

    task automatic test_stream();
        obs_t o;
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h3000 + 32'(i * 4);
            drive_both(1'b1, 1'b0, 1'b1, pc, 2'd2, 1'b0, 5'h0, 1'b1, 5'd9);
            step();
            for (int d = 0; d < 2; d++) begin
                snap(d, o);
                n_checks++;
                if ({o.valid, o.pc, o.tnew, o.rw, o.wreg, o.data} !==
                    {1'b1, pc, 2'd1, 1'b1, 5'd9, mk_data(pc)}) begin
                    n_fail++;
                    $display("FAIL stream[%0d] dut%0d: got valid=%0b pc=%h tnew=%0d rw=%0b wreg=%0d, want valid=1 pc=%h tnew=1 rw=1 wreg=9",
                             i, d, o.valid, o.pc, o.tnew, o.rw, o.wreg, pc);
                end
            end
        end
        drive_both(1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 5'h0, 1'b1, 5'd9);
        step();
        for (int d = 0; d < 2; d++) begin
            snap(d, o);
            n_checks++;
            if ({o.valid, o.rw} !== 2'b00) begin
                n_fail++;
                $display("FAIL stream_idle dut%0d: got valid=%0b rw=%0b, want 0 0", d, o.valid, o.rw);
            end
        end
    endtask

    task automatic test_tnew_sat();
        obs_t o;
        logic [1:0] tn, tn_exp;
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            tn     = (i == 0) ? 2'd0 : (i == 1) ? 2'd3 : 2'd1;
            tn_exp = (i == 1) ? 2'd2 : 2'd0;
            pc     = 32'h3020 + 32'(i * 4);
            drive_both(1'b1, 1'b0, 1'b1, pc, tn, 1'b1, 5'h0C, 1'b0, 5'd31);
            step();
            for (int d = 0; d < 2; d++) begin
                snap(d, o);
                n_checks++;
                if ({o.valid, o.pc, o.tnew, o.ds, o.exc, o.rw, o.wreg} !==
                    {1'b1, pc, tn_exp, 1'b1, 5'h0C, 1'b0, 5'd31}) begin
                    n_fail++;
                    $display("FAIL tnew_sat[%0d] dut%0d: got valid=%0b pc=%h tnew=%0d ds=%0b exc=%h rw=%0b, want valid=1 pc=%h tnew=%0d ds=1 exc=0c rw=0",
                             i, d, o.valid, o.pc, o.tnew, o.ds, o.exc, o.rw, pc, tn_exp);
                end
            end
        end
    endtask

    task automatic test_bubble();
        obs_t o;
        drive_both(1'b1, 1'b1, 1'b1, 32'h3010, 2'd3, 1'b1, 5'h04, 1'b1, 5'd3);
        #1;
        for (int d = 0; d < 2; d++) begin
            snap(d, o);
            n_checks++;
            if (o.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bubble_ready dut%0d: got in_ready=%0b, want 0", d, o.in_ready);
            end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            snap(d, o);
            n_checks++;
            if ({o.valid, o.pc, o.ds, o.exc, o.rw, o.tnew} !==
                {1'b0, 32'h3010, 1'b1, 5'h0, 1'b0, 2'd0}) begin
                n_fail++;
                $display("FAIL bubble dut%0d: got valid=%0b pc=%h ds=%0b exc=%h rw=%0b tnew=%0d, want valid=0 pc=3010 ds=1 exc=0 rw=0 tnew=0",
                         d, o.valid, o.pc, o.ds, o.exc, o.rw, o.tnew);
            end
        end
        drive_both(1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 5'h0, 1'b0, 5'd0);
        step();
    endtask

    task automatic test_backpressure();
        obs_t        o;
        int          n_acc = 0;
        int          n_out = 0;
        logic [31:0] got_pc [4];
        int          got_cyc [4];
        logic        ordy;
        for (int cyc = 0; cyc < 10; cyc++) begin
            ordy = (cyc >= 3);
            drive_one(1, n_acc < 3, 1'b0, ordy, 32'h3000 + 32'(n_acc * 4), 2'd2, 1'b0, 5'h0, 1'b1, 5'd4);
            @(negedge clk);
            snap(1, o);
            if (cyc == 2) begin
                n_checks++;
                if (n_acc !== 2 || o.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall: got accepts=%0d in_ready=%0b, want accepts=2 in_ready=0", n_acc, o.in_ready);
                end
            end
            if (o.valid && ordy) begin
                if (n_out < 4) begin
                    got_pc[n_out]  = o.pc;
                    got_cyc[n_out] = cyc;
                end
                n_out++;
            end
            if ((n_acc < 3) && o.in_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (n_out != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs, want 3", n_out);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (got_pc[k] !== 32'h3000 + 32'(k * 4) || got_cyc[k] != 3 + k) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got pc=%h at cycle %0d, want pc=%h at cycle %0d",
                             k, got_pc[k], got_cyc[k], 32'h3000 + 32'(k * 4), 3 + k);
                end
            end
        end
    endtask

    task automatic test_flush();
        obs_t o;
        drive_both(1'b1, 1'b0, 1'b0, 32'h3100, 2'd1, 1'b0, 5'h0, 1'b1, 5'd2);
        step();
        drive_both(1'b1, 1'b0, 1'b0, 32'h3104, 2'd1, 1'b0, 5'h0, 1'b1, 5'd2);
        step();
        snap(1, o);
        n_checks++;
        if ({o.valid, o.pc, o.in_ready} !== {1'b1, 32'h3100, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_setup: got valid=%0b pc=%h in_ready=%0b, want 1 3100 0", o.valid, o.pc, o.in_ready);
        end
        set_flush(1'b1);
        drive_both(1'b1, 1'b0, 1'b0, 32'h3108, 2'd1, 1'b0, 5'h0, 1'b1, 5'd2);
        step();
        set_flush(1'b0);
        drive_both(1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 5'h0, 1'b0, 5'd0);
        #1;
        for (int d = 0; d < 2; d++) begin
            snap(d, o);
            n_checks++;
            if ({o.valid, o.pc, o.exc, o.rw, o.tnew, o.in_ready} !==
                {1'b0, 32'h0000_4180, 5'h0, 1'b0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL flush dut%0d: got valid=%0b pc=%h exc=%h rw=%0b tnew=%0d in_ready=%0b, want valid=0 pc=4180 exc=0 rw=0 tnew=0 in_ready=1",
                         d, o.valid, o.pc, o.exc, o.rw, o.tnew, o.in_ready);
            end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            snap(d, o);
            n_checks++;
            if (o.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_skid_cleared dut%0d: got valid=%0b pc=%h, want valid=0", d, o.valid, o.pc);
            end
        end
        set_flush(1'b1);
        drive_both(1'b1, 1'b0, 1'b1, 32'h3200, 2'd2, 1'b0, 5'h0, 1'b1, 5'd6);
        step();
        set_flush(1'b0);
        drive_both(1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 5'h0, 1'b0, 5'd0);
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 2; d++) begin
                snap(d, o);
                n_checks++;
                if (o.valid !== 1'b0 || (c == 0 && o.pc !== 32'h0000_4180)) begin
                    n_fail++;
                    $display("FAIL flush_vs_tin[%0d] dut%0d: got valid=%0b pc=%h, want valid=0 (pc=4180 on first cycle)",
                             c, d, o.valid, o.pc);
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        exp_t        q0[$];
        exp_t        q1[$];
        exp_t        e;
        obs_t        o;
        logic [31:0] np [2];
        logic        v [2];
        logic        r [2];
        logic        bub;
        logic [1:0]  tn [2];
        logic        empty;
        np[0] = 32'h0001_0000;
        np[1] = 32'h0002_0000;
        for (int cyc = 0; cyc < 10010; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (cyc < 10000) begin
                    v[d] = ($urandom_range(0, 3) != 0);
                    bub  = ($urandom_range(0, 9) == 0);
                    r[d] = ($urandom_range(0, 1) != 0);
                end else begin
                    v[d] = 1'b0;
                    bub  = 1'b0;
                    r[d] = 1'b1;
                end
                tn[d] = 2'($urandom_range(0, 3));
                drive_one(d, v[d], bub, r[d], np[d], tn[d], 1'b0, 5'h0, 1'b1, 5'd1);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                snap(d, o);
                if (o.valid && r[d]) begin
                    n_checks++;
                    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        n_fail++;
                        $display("FAIL random_extra dut%0d cycle %0d: got pc=%h, want no output", d, cyc, o.pc);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if (o.pc !== e.pc || o.tnew !== e.tnew || o.data !== mk_data(e.pc) || o.rw !== 1'b1) begin
                            n_fail++;
                            $display("FAIL random_order dut%0d cycle %0d: got pc=%h tnew=%0d rw=%0b, want pc=%h tnew=%0d rw=1",
                                     d, cyc, o.pc, o.tnew, o.rw, e.pc, e.tnew);
                        end
                    end
                end
                if (v[d] && o.in_ready) begin
                    e.pc   = np[d];
                    e.tnew = (tn[d] == 2'd0) ? 2'd0 : 2'(tn[d] - 2'd1);
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    np[d] = np[d] + 32'd4;
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d/%0d undelivered, want 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_stream();
        test_tnew_sat();
        test_bubble();
        test_backpressure();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
